// File: rtl/s27_lane_array_misr.sv
// s27_lane_array_misr
// Parametrised array of independent s27 next-state lanes with clear/enable
// control, plus a start/busy/done run controller that compacts the per-lane
// G17 values into a multiple-input signature register (MISR). A run takes
// RUN_LEN enabled steps; the final signature is compared against a software
// golden value.
module s27_lane_array_misr #(
  parameter int                LANES     = 4,
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = 16'h8016,
  parameter logic [MISR_W-1:0] SEED      = 16'hFFFF,
  parameter int                RUN_LEN   = 64,
  parameter int                CNT_W     = $clog2(RUN_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clear,
  input  logic               start,
  input  logic [LANES-1:0]   g0,
  input  logic [LANES-1:0]   g1,
  input  logic [LANES-1:0]   g2,
  input  logic [LANES-1:0]   g3,
  output logic [LANES-1:0]   g17,
  output logic [3*LANES-1:0] lane_state,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   step_cnt,
  output logic [MISR_W-1:0]  signature
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } run_state_t;

  localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);

  logic [3*LANES-1:0] lane_next;
  logic [LANES-1:0]   g17_next;
  logic [MISR_W-1:0]  g17_ext;
  logic [MISR_W-1:0]  misr_next;
  logic               step;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last_step;

  run_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [MISR_W-1:0]  sig_d;

  // A run step happens only when enabled and not being cleared.
  assign step = en & ~clear;

  // Combinational s27 next-state logic, one copy per lane.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic s5, s6, s7;
    logic n8, n9, n10, n11, n12, n13, n14, n15, n16;

    assign s5  = lane_state[3*i];
    assign s6  = lane_state[3*i+1];
    assign s7  = lane_state[3*i+2];

    assign n14 = ~g0[i];
    assign n12 = ~(g1[i] | s7);
    assign n8  = n14 & s6;
    assign n15 = n12 | n8;
    assign n16 = g3[i] | n8;
    assign n9  = ~(n16 & n15);
    assign n11 = ~(s5 | n9);
    assign n10 = ~(n14 | n11);
    assign n13 = ~(g2[i] | n12);

    // Packed as {G7,G6,G5} = {G13,G11,G10}.
    assign lane_next[3*i +: 3] = {n13, n11, n10};
    assign g17_next[i]         = ~n11;
  end

  // Lane registers: clear has priority over the step enable.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_state <= '0;
      g17        <= '0;
    end else if (clear) begin
      lane_state <= '0;
      g17        <= '0;
    end else if (en) begin
      lane_state <= lane_next;
      g17        <= g17_next;
    end
  end

  // Zero-extend the new G17 vector so lanes land on the signature LSBs.
  always_comb begin
    g17_ext                = '0;
    g17_ext[LANES-1:0]     = g17_next;
  end

  // Galois-style MISR shift with the lane outputs folded in.
  assign misr_next = {signature[MISR_W-2:0], 1'b0}
                   ^ (signature[MISR_W-1] ? MISR_POLY : '0)
                   ^ g17_ext;

  assign cnt_inc   = step_cnt + 1'b1;
  assign last_step = (cnt_inc == RUN_LEN_C);

  // Run controller next-state, count and signature logic.
  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = step_cnt;
    sig_d   = signature;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          sig_d   = SEED;
        end
      end
      ST_RUN: begin
        if (step) begin
          cnt_d = cnt_inc;
          sig_d = misr_next;
          if (last_step) begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Run controller registers; reset discards any partial signature.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      step_cnt  <= '0;
      signature <= SEED;
    end else begin
      state_q   <= state_d;
      step_cnt  <= cnt_d;
      signature <= sig_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule
